// File: rtl/pool_pkg.sv
// pool_pkg: shared constants for the 2x2 pooling stream (mode encodings, default pixel width)
package pool_pkg;
    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_AVG = 1'b1;
    localparam int   DW_DEF   = 8;
endpackage

// File: rtl/pool_stream_if.sv
// pool_stream_if: pixel stream in/out handshake bundle
//   in_data/in_valid/in_ready          : input pixel stream (raster order)
//   out_data/out_valid/out_ready/out_last : pooled output stream, out_last marks frame end
//   slave  : pooling block side, master : producer/consumer side
interface pool_stream_if import pool_pkg::*; #(parameter int DW = DW_DEF);
    logic signed [DW-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    modport slave (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid, out_last);
    modport master(output in_data, in_valid, out_ready, input in_ready, out_data, out_valid, out_last);
endinterface

// File: rtl/pool_pair.sv
// pool_pair: combines two signed values as max or sum (one bit wider)
//   mode : MODE_MAX selects signed max, MODE_AVG selects signed sum
//   a, b : W-bit signed operands
//   y    : W+1-bit signed result (max is sign-extended)
module pool_pair import pool_pkg::*; #(
    parameter int W = DW_DEF
) (
    input  logic                mode,
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W:0]   y
);
    logic signed [W:0] ax, bx;
    assign ax = a;
    assign bx = b;
    always_comb y = (mode == MODE_AVG) ? ax + bx : ((ax > bx) ? ax : bx);
endmodule

// File: rtl/pool_stream.sv
// pool_stream: streaming 2x2 max/average pooling over a raster-order feature map
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   mode  : pooling mode, sampled at the first pixel of each frame
//   s     : pixel stream bundle (slave side), output latency 1 after the completing pixel
module pool_stream import pool_pkg::*; #(
    parameter int DW    = DW_DEF,
    parameter int IMG_W = 24,
    parameter int IMG_H = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mode,
    pool_stream_if.slave s
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int LN = IMG_W / 2;
    localparam int LW = (LN > 1) ? $clog2(LN) : 1;

    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic                 mode_q;
    logic signed [DW-1:0] held;
    logic signed [DW:0]   lb [LN];
    logic signed [DW:0]   p;
    logic signed [DW+1:0] v;
    logic signed [DW-1:0] res;
    logic [LW-1:0]        idx;
    logic                 acc, col_end, row_end;

    assign s.in_ready = !s.out_valid || s.out_ready;
    assign acc        = s.in_valid && s.in_ready;
    assign col_end    = col == CW'(IMG_W - 1);
    assign row_end    = row == RW'(IMG_H - 1);
    assign idx        = LW'(col >> 1);

    pool_pair #(.W(DW))     u_h (.mode(mode_q), .a(held),    .b(s.in_data), .y(p));
    pool_pair #(.W(DW + 1)) u_v (.mode(mode_q), .a(lb[idx]), .b(p),         .y(v));

    // four-pixel sum divided by 4 with floor; max already fits in DW bits
    assign res = (mode_q == MODE_AVG) ? DW'(v >>> 2) : DW'(v);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col         <= '0;
            row         <= '0;
            mode_q      <= MODE_MAX;
            held        <= '0;
            s.out_valid <= 1'b0;
            s.out_last  <= 1'b0;
            s.out_data  <= '0;
        end else begin
            if (acc) begin
                col <= col_end ? '0 : col + 1'b1;
                if (col_end) row <= row_end ? '0 : row + 1'b1;
                if (col == '0 && row == '0) mode_q <= mode;
                if (!col[0]) held <= s.in_data;
            end
            if (acc && col[0] && row[0]) begin
                s.out_data  <= res;
                s.out_valid <= 1'b1;
                s.out_last  <= col_end && row_end;
            end else if (s.out_ready) begin
                s.out_valid <= 1'b0;
            end
        end
    end

    // even rows park their horizontal pair results for the odd row below
    always_ff @(posedge clk) begin
        if (acc && col[0] && !row[0]) lb[idx] <= p;
    end
endmodule

// File: tb/tb_pool_stream.sv
// tb_pool_stream: directed checks on a 4x2 instance plus random-handshake 24x24 frames
module tb_pool_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic s_rst_n, b_rst_n, s_mode, b_mode;
    int   errors = 0;
    int   checks = 0;

    pool_stream_if #(8) s();
    pool_stream_if #(8) b();

    pool_stream #(.DW(8), .IMG_W(4), .IMG_H(2)) dut_s (
        .clk(clk), .rst_n(s_rst_n), .mode(s_mode), .s(s.slave));
    pool_stream #(.DW(8), .IMG_W(24), .IMG_H(24)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .mode(b_mode), .s(b.slave));

    int fa[8]  = '{1, -5, 7, 3, 2, 9, -8, 0};
    int fm1[8] = '{default: -1};
    int fhi[8] = '{default: 127};
    int flo[8] = '{default: -128};

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [8:0] sq[$];
    always @(negedge clk) if (s.out_valid && s.out_ready) sq.push_back({s.out_last, s.out_data});

    logic [8:0] bexp[$];
    logic [8:0] be;
    int bouts = 0;
    int blasts = 0;
    always @(negedge clk) begin
        if (b.out_valid && b.out_ready) begin
            bouts++;
            if (b.out_last) blasts++;
            if (bexp.size() == 0) check("big_extra", 1, 0);
            else begin
                be = bexp.pop_front();
                check("big_data", b.out_data, $signed(be[7:0]));
                check("big_last", b.out_last, be[8]);
            end
        end
    end

    task automatic push(input int d);
        logic rdy;
        s.in_data  = 8'(d);
        s.in_valid = 1'b1;
        for (int n = 0; n <= 100; n++) begin
            @(negedge clk);
            rdy = s.in_ready;
            @(posedge clk);
            #1;
            if (rdy) return;
        end
        check("push_timeout", 0, 1);
    endtask

    task automatic idle_wait();
        s.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic frame(input int v[8]);
        foreach (v[i]) push(v[i]);
        idle_wait();
    endtask

    task automatic expect2(input string tag, input int e0, input int e1);
        check({tag, "_count"}, sq.size(), 2);
        if (sq.size() == 2) begin
            check({tag, "_d0"}, $signed(sq[0][7:0]), e0);
            check({tag, "_l0"}, sq[0][8], 0);
            check({tag, "_d1"}, $signed(sq[1][7:0]), e1);
            check({tag, "_l1"}, sq[1][8], 1);
        end
        sq.delete();
    endtask

    task automatic small_seq();
        s_rst_n = 1'b0; s_mode = 1'b0;
        s.in_valid = 1'b0; s.in_data = '0; s.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", s.out_valid, 0);
        check("rst_out_data", s.out_data, 0);
        check("rst_out_last", s.out_last, 0);
        check("rst_in_ready", s.in_ready, 1);
        s_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(fa[i]);
            if (i == 5) begin
                check("lat_valid", s.out_valid, 1);
                check("lat_data", s.out_data, 9);
            end
        end
        idle_wait();
        expect2("max", 9, 7);
        s_mode = 1'b1;
        frame(fa);  expect2("avg", 1, 0);
        frame(fm1); expect2("avg_m1", -1, -1);
        frame(fhi); expect2("avg_hi", 127, 127);
        frame(flo); expect2("avg_lo", -128, -128);
        s_mode = 1'b0;
        s.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(fa[i]);
        s.in_data = -8'sd8; s.in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", s.in_ready, 0);
            check("bp_out_valid", s.out_valid, 1);
            check("bp_out_data", s.out_data, 9);
        end
        @(posedge clk);
        #1;
        s.out_ready = 1'b1;
        push(-8); push(0);
        idle_wait();
        expect2("bp", 9, 7);
        s_mode = 1'b0;
        push(fa[0]);
        s_mode = 1'b1;
        for (int i = 1; i < 8; i++) push(fa[i]);
        idle_wait();
        expect2("tog", 9, 7);
        frame(fa); expect2("tog_next", 1, 0);
        s_mode = 1'b0;
        for (int i = 0; i < 6; i++) push(fa[i]);
        s.in_valid = 1'b0;
        s_rst_n = 1'b0;
        @(posedge clk);
        #1;
        s_rst_n = 1'b1;
        check("rst_mid_valid", s.out_valid, 0);
        sq.delete();
        s_mode = 1'b1;
        frame(fa); expect2("rst_restart", 1, 0);
    endtask

    task automatic big_seq();
        int pix[24][24];
        int m, sum, n;
        logic acc;
        b_rst_n = 1'b0; b_mode = 1'b0;
        b.in_valid = 1'b0; b.in_data = '0; b.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        b_rst_n = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < 24; r++)
                for (int c = 0; c < 24; c++) pix[r][c] = int'($urandom_range(0, 255)) - 128;
            for (int wr = 0; wr < 12; wr++)
                for (int wc = 0; wc < 12; wc++) begin
                    m = pix[2*wr][2*wc]; sum = 0;
                    for (int k = 0; k < 4; k++) begin
                        if (pix[2*wr + k/2][2*wc + k%2] > m) m = pix[2*wr + k/2][2*wc + k%2];
                        sum += pix[2*wr + k/2][2*wc + k%2];
                    end
                    if (f == 1) m = sum >>> 2;
                    bexp.push_back({(wr == 11 && wc == 11) ? 1'b1 : 1'b0, 8'(m)});
                end
            b_mode = (f == 1);
            for (int r = 0; r < 24; r++)
                for (int c = 0; c < 24; c++) begin
                    b.in_data = 8'(pix[r][c]);
                    n = 0;
                    do begin
                        b.in_valid  = ($urandom_range(0, 3) != 0);
                        b.out_ready = ($urandom_range(0, 3) != 0);
                        @(negedge clk);
                        acc = b.in_valid && b.in_ready;
                        @(posedge clk);
                        #1;
                        n++;
                    end while (!acc && n < 1000);
                    if (!acc) check("big_push_timeout", 0, 1);
                end
        end
        b.in_valid = 1'b0;
        b.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("big_outputs", bouts, 432);
        check("big_lasts", blasts, 3);
        check("big_pending", bexp.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        fork
            small_seq();
            big_seq();
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pool_stream.md
POOL_STREAM -- requirements
Module: pool_stream

Interface
REQ-001 SHALL have parameter DW, default 8, meaning signed pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 24, meaning input feature-map width in pixels; even, >=2.
REQ-003 SHALL have parameter IMG_H, default 24, meaning input feature-map height in rows; even, >=2.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port mode  input  1  0 = 2x2 max pool, 1 = 2x2 average pool.
REQ-007 SHALL have port in_data  input  DW  signed pixel, raster order, row-major.
REQ-008 SHALL have port in_valid  input  1  in_data valid.
REQ-009 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-010 SHALL have port out_data  output  DW  signed pooled pixel.
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-013 SHALL have port out_last  output  1  marks final pooled pixel of a frame; qualified by out_valid.

Function
REQ-014 SHALL accept a pixel only on in_valid && in_ready; it SHALL produce an output only on out_valid && out_ready.
REQ-015 SHALL drive in_ready = !out_valid || out_ready, combinationally; no other stall source.
REQ-016 SHALL track column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), both advancing on accepted input only.
REQ-017 At col = IMG_W-1, col SHALL wrap to 0 and row SHALL increment; at row = IMG_H-1 and col = IMG_W-1, both SHALL wrap to 0 (next frame).
REQ-018 SHALL latch mode into mode_q on acceptance of pixel (0,0); mode changes mid-frame SHALL be ignored until the next frame.
REQ-019 Even col: pixel SHALL be held in a DW-bit pair register; odd col: pair result p = combine(held, in_data).
REQ-020 combine SHALL be signed max in mode_q=0 and signed sum of width DW+1 in mode_q=1.
REQ-021 Even row, odd col: p SHALL be written to line buffer entry col/2 (IMG_W/2 entries, DW+1 bits).
REQ-022 Odd row, odd col: result SHALL be combine(linebuf[col/2], p); max mode result = signed max, avg mode result = (DW+2-bit sum) arithmetic-shift-right 2 (floor), truncated to DW.
REQ-023 Result SHALL register into out_data with out_valid=1 on the cycle after the completing input is accepted (latency 1).
REQ-024 out_last SHALL be 1 with the output produced from input (IMG_H-1, IMG_W-1), else 0.
REQ-025 out_valid SHALL hold, with out_data/out_last stable, until out_ready; simultaneous output consume and new completing input SHALL reload out_data without a bubble.
REQ-026 Each frame SHALL yield exactly (IMG_W/2)*(IMG_H/2) outputs.

Reset
REQ-027 While rst_n=0 at a clock edge: col=0, row=0, out_valid=0, out_last=0, out_data=0, mode_q=0, pair register=0.
REQ-028 Line buffer contents SHALL not require reset; they are always written before being read.
REQ-029 Reset mid-frame SHALL discard the partial frame; the first accepted pixel after reset is (0,0).

Structure
REQ-030 Package pool_pkg SHALL hold MODE_MAX=0, MODE_AVG=1 constants and default DW.
REQ-031 One combinational sub-module pool_pair SHALL implement combine (max or sum, parametrised width), instantiated for horizontal and vertical stages.
REQ-032 Line buffer SHALL be a register array, single write and single read per cycle.

Verification
REQ-033 IMG_W=4, IMG_H=2, max mode, rows {1,-5,7,3},{2,9,-8,0}, out_ready=1 -> outputs 9, 7; out_last on 7.
REQ-034 Same pixels, avg mode -> (1-5+2+9)>>>2 = 1, (7+3-8+0)>>>2 = 0; all-(-1) window -> -1; all 127 -> 127; all -128 -> -128.
REQ-035 out_ready held 0 for 5 cycles with out_valid=1 -> in_ready=0, out_data stable, no input lost; release -> stream resumes.
REQ-036 Toggle mode at pixel (0,1) of a max frame -> whole frame max; next frame uses new mode.
REQ-037 Assert rst_n=0 mid-frame for one cycle -> out_valid=0, restart frame gives correct outputs and out_last.
REQ-038 Random in_valid/out_ready, 3 back-to-back 24x24 frames vs reference model -> exactly 144 outputs per frame, all matching.
